// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad debounce/encoder block.
package calc_pkg;

  localparam int DIGIT_W = 4;
  localparam int KEY_N   = 10;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/keypad_debounce_encoder_if.sv
// Keypad-side bundle: raw active-low keys in, decoded digit and status pulses out.
interface keypad_debounce_encoder_if;
  import calc_pkg::*;

  logic [KEY_N-1:0]   A;
  logic [DIGIT_W-1:0] DIGIT;
  logic               KEY_VALID;
  logic               KEY_HELD;
  logic               MULTI_ERR;

  modport master (
    output A,
    input  DIGIT, KEY_VALID, KEY_HELD, MULTI_ERR
  );

  modport slave (
    input  A,
    output DIGIT, KEY_VALID, KEY_HELD, MULTI_ERR
  );

endinterface

// File: rtl/keypad_encoder.sv
// Maps an active-high key vector to the index of its lowest set key and flags a single-key press.
module keypad_encoder
  import calc_pkg::*;
(
  input  logic [KEY_N-1:0]   keys,
  output logic [DIGIT_W-1:0] index,
  output logic               one_hot
);

  // Scan from the top so the lowest pressed key wins.
  always_comb begin
    index = '0;
    for (int i = KEY_N - 1; i >= 0; i--) begin
      if (keys[i]) index = DIGIT_W'(i);
    end
  end

  assign one_hot = (keys != '0) && ((keys & (keys - KEY_N'(1))) == '0);

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Synchronizes a raw keypad, debounces press/release and reports the accepted digit.
module keypad_debounce_encoder
  import calc_pkg::*;
#(
  parameter int DB_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  keypad_debounce_encoder_if.slave  kp
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [KEY_N-1:0]   sync1, sync2;
  logic [KEY_N-1:0]   k;
  logic [KEY_N-1:0]   snap, snap_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  state_t             state, state_nxt;

  logic [DIGIT_W-1:0] enc_index;
  logic               enc_one_hot;
  logic               press_done;

  logic [DIGIT_W-1:0] digit_q, digit_nxt;
  logic               valid_q, valid_nxt;
  logic               held_q, held_nxt;
  logic               err_q, err_nxt;

  // Synchronizer resets to all-ones so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kp.A;
      sync2 <= sync1;
    end
  end

  assign k = ~sync2;

  keypad_encoder u_encoder (
    .keys    (k),
    .index   (enc_index),
    .one_hot (enc_one_hot)
  );

  // Press is accepted on the cycle the counter has already seen DB_CYCLES-1 stable cycles.
  assign press_done = (state == DB_PRESS) && (k != '0) && (k == snap) && (cnt >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    case (state)
      IDLE: begin
        if (k != '0) begin
          state_nxt = DB_PRESS;
          snap_nxt  = k;
          cnt_nxt   = '0;
        end
      end
      DB_PRESS: begin
        if (k == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (k != snap) begin
          snap_nxt = k;
          cnt_nxt  = '0;
        end else if (press_done) begin
          state_nxt = HELD;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      HELD: begin
        // Roll-over and added keys are ignored until every key is up.
        if (k == '0) begin
          state_nxt = DB_RELEASE;
          cnt_nxt   = '0;
        end
      end
      DB_RELEASE: begin
        if (k != '0) begin
          cnt_nxt = '0;
        end else if (cnt >= CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        snap_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    valid_nxt = press_done && enc_one_hot;
    err_nxt   = press_done && !enc_one_hot;
    digit_nxt = valid_nxt ? enc_index : digit_q;
    held_nxt  = (state_nxt == HELD) || (state_nxt == DB_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      digit_q <= digit_nxt;
      valid_q <= valid_nxt;
      held_q  <= held_nxt;
      err_q   <= err_nxt;
    end
  end

  assign kp.DIGIT     = digit_q;
  assign kp.KEY_VALID = valid_q;
  assign kp.KEY_HELD  = held_q;
  assign kp.MULTI_ERR = err_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder with DB_CYCLES=4: vector table plus reset/timing sequences.
module tb_keypad_debounce_encoder;

  localparam logic [9:0] NONE  = 10'b1111111111;
  localparam logic [9:0] KEY0  = 10'b1111111110;
  localparam logic [9:0] KEY2  = 10'b1111111011;
  localparam logic [9:0] KEY3  = 10'b1111110111;
  localparam logic [9:0] KEY7  = 10'b1101111111;
  localparam logic [9:0] KEY8  = 10'b1011111111;
  localparam logic [9:0] KEY9  = 10'b0111111111;
  localparam logic [9:0] K34   = 10'b1111100111;
  localparam logic [9:0] K89   = 10'b0011111111;

  typedef struct {
    string      name;
    logic [9:0] a;
    int         cycles;
    int         push;
    int         err;
    logic       held;
    logic [3:0] digit;
  } vec_t;

  logic clk;
  logic rst_n;
  keypad_debounce_encoder_if kif ();

  keypad_debounce_encoder #(.DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests;
  int         fails;
  int         err_seen;
  bit         mon_en;
  logic [3:0] exp_q[$];
  vec_t       vecs[20];

  function automatic vec_t mk(string n, logic [9:0] a, int cyc, int push, int err,
                              logic held, logic [3:0] dig);
    vec_t v;
    v.name = n; v.a = a; v.cycles = cyc; v.push = push;
    v.err = err; v.held = held; v.digit = dig;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    logic [3:0] d;
    if (kif.MULTI_ERR) err_seen++;
    if (kif.KEY_VALID && kif.MULTI_ERR) begin
      tests++;
      fails++;
      $display("FAIL pulse_overlap: KEY_VALID and MULTI_ERR both 1, required at most one");
    end
    if (kif.KEY_VALID) begin
      if (exp_q.size() > 0) begin
        d = exp_q.pop_front();
        check("valid_digit", 16'(kif.DIGIT), 16'(d));
      end else begin
        tests++;
        fails++;
        $display("FAIL spurious_valid: KEY_VALID=1 DIGIT=%0d, required no pulse", kif.DIGIT);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_en) monitor();
  endtask

  task automatic run_vectors(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].push >= 0) exp_q.push_back(4'(vecs[i].push));
      err_seen = 0;
      kif.A = vecs[i].a;
      repeat (vecs[i].cycles) tick();
      check({vecs[i].name, "_pending"}, 16'(exp_q.size()), 16'd0);
      check({vecs[i].name, "_err"}, 16'(err_seen), 16'(vecs[i].err));
      check({vecs[i].name, "_held"}, 16'(kif.KEY_HELD), 16'(vecs[i].held));
      check({vecs[i].name, "_digit"}, 16'(kif.DIGIT), 16'(vecs[i].digit));
      exp_q.delete();
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    err_seen = 0;
    mon_en   = 1'b0;

    vecs[0]  = mk("rel7",    NONE, 12, -1, 0, 1'b0, 4'd7);
    vecs[1]  = mk("press3",  KEY3, 20,  3, 0, 1'b1, 4'd3);
    vecs[2]  = mk("bnc8_a",  KEY8,  2, -1, 0, 1'b0, 4'd3);
    vecs[3]  = mk("bnc0_a",  NONE,  2, -1, 0, 1'b0, 4'd3);
    vecs[4]  = mk("bnc8_b",  KEY8,  2, -1, 0, 1'b0, 4'd3);
    vecs[5]  = mk("bnc0_b",  NONE,  2, -1, 0, 1'b0, 4'd3);
    vecs[6]  = mk("bnc8_c",  KEY8,  2, -1, 0, 1'b0, 4'd3);
    vecs[7]  = mk("bnc0_c",  NONE,  2, -1, 0, 1'b0, 4'd3);
    vecs[8]  = mk("hold8",   KEY8, 10,  8, 0, 1'b1, 4'd8);
    vecs[9]  = mk("rel8",    NONE, 10, -1, 0, 1'b0, 4'd8);
    vecs[10] = mk("multi34", K34,  10, -1, 1, 1'b1, 4'd8);
    vecs[11] = mk("rel34",   NONE, 10, -1, 0, 1'b0, 4'd8);
    vecs[12] = mk("roll8",   KEY8, 10,  8, 0, 1'b1, 4'd8);
    vecs[13] = mk("add9",    K89,  10, -1, 0, 1'b1, 4'd8);
    vecs[14] = mk("drop8",   KEY9, 10, -1, 0, 1'b1, 4'd8);
    vecs[15] = mk("relall",  NONE, 10, -1, 0, 1'b0, 4'd8);
    vecs[16] = mk("press9",  KEY9, 10,  9, 0, 1'b1, 4'd9);
    vecs[17] = mk("rel9",    NONE, 10, -1, 0, 1'b0, 4'd9);
    vecs[18] = mk("press0",  KEY0, 10,  0, 0, 1'b1, 4'd0);
    vecs[19] = mk("rel0",    NONE, 10, -1, 0, 1'b0, 4'd0);

    // Reset with key 7 down, then the key is debounced from scratch.
    rst_n = 1'b0;
    kif.A = KEY7;
    repeat (3) tick();
    check("rst_digit", 16'(kif.DIGIT), 16'd0);
    check("rst_valid", 16'(kif.KEY_VALID), 16'd0);
    check("rst_held",  16'(kif.KEY_HELD), 16'd0);
    check("rst_err",   16'(kif.MULTI_ERR), 16'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("rst_valid_e%0d", e), 16'(kif.KEY_VALID), (e == 7) ? 16'd1 : 16'd0);
      if (e == 7) check("rst_digit7", 16'(kif.DIGIT), 16'd7);
    end
    check("rst_held_after", 16'(kif.KEY_HELD), 16'd1);

    mon_en = 1'b1;
    run_vectors(0, 1);

    // Release timing: KEY_HELD drops on the 7th edge after A goes high.
    kif.A = NONE;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check($sformatf("rel3_held_e%0d", e), 16'(kif.KEY_HELD), (e < 7) ? 16'd1 : 16'd0);
    end

    run_vectors(2, 19);

    // Reset during the press debounce discards the press.
    kif.A = KEY2;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_digit", 16'(kif.DIGIT), 16'd0);
    check("mid_rst_held",  16'(kif.KEY_HELD), 16'd0);
    kif.A = NONE;
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("mid_rst_digit_after", 16'(kif.DIGIT), 16'd0);
    check("mid_rst_held_after",  16'(kif.KEY_HELD), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_debounce_encoder.md
KEYPAD_DEBOUNCE_ENCODER -- requirements
Module: keypad_debounce_encoder

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a press or a release, legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 A  input  10  raw keypad, active-low; A[n]=0 means digit key n pressed; asynchronous to clk.
REQ-005 DIGIT  output  4  binary value 0..9 of the last accepted key; held until the next acceptance.
REQ-006 KEY_VALID  output  1  one-cycle pulse; DIGIT is updated in the same cycle.
REQ-007 KEY_HELD  output  1  level; high from acceptance until the release is debounced.
REQ-008 MULTI_ERR  output  1  one-cycle pulse when a debounced press has more than one key down.

Function
REQ-009 A shall pass through a two-flop synchronizer and be inverted to active-high key vector K before any other use.
REQ-010 FSM states shall be IDLE, DB_PRESS, HELD and DB_RELEASE.
REQ-011 IDLE -> DB_PRESS when K != 0: snapshot S <= K, counter <= 0.
REQ-012 In DB_PRESS, K == S shall increment the counter.
REQ-013 In DB_PRESS, K != S with K != 0 shall reload S <= K and counter <= 0.
REQ-014 In DB_PRESS, K == 0 shall return the FSM to IDLE with no output pulse.
REQ-015 In DB_PRESS, when the counter reaches DB_CYCLES-1 with K == S and S one-hot, the block shall go to HELD, load DIGIT with the index of S, and pulse KEY_VALID for one cycle.
REQ-016 The same condition with more than one bit set in S shall go to HELD, pulse MULTI_ERR, and leave DIGIT unchanged, with no KEY_VALID.
REQ-017 Latency: KEY_VALID shall be high in the cycle after the (DB_CYCLES+3)th rising edge, counting the edge that first samples the stable press as edge 1.
REQ-018 In HELD, K == 0 shall move to DB_RELEASE with counter <= 0; key changes while not all released shall be ignored, with no new pulse.
REQ-019 In DB_RELEASE, K == 0 shall increment the counter, K != 0 shall reset the counter to 0, and reaching DB_CYCLES-1 shall return to IDLE.
REQ-020 KEY_HELD shall be high exactly in HELD and DB_RELEASE following a KEY_VALID or MULTI_ERR.
REQ-021 KEY_VALID and MULTI_ERR shall never be high in the same cycle, and each shall pulse at most once per press-release cycle.
REQ-022 The counter shall be 16 bits wide and saturate; it shall never wrap.
REQ-023 Bounce shorter than DB_CYCLES shall produce no pulse.
REQ-024 All outputs shall be registered.

Reset
REQ-025 On rst_n low: state IDLE, counter 0, S 0, synchronizer flops 1 (released), DIGIT 0, KEY_VALID 0, KEY_HELD 0, MULTI_ERR 0.
REQ-026 Reset asserted mid-debounce or mid-hold shall discard the press, with no pulse after release of reset until a fresh full debounce completes.
REQ-027 A key held down through reset deassertion shall be treated as a new press and debounced from IDLE.

Structure
REQ-028 Shared package calc_pkg shall hold the FSM state enum, the DIGIT width constant (4), and the key count constant (10).
REQ-029 One combinational sub-module, keypad_encoder, shall map the 10-bit K to a 4-bit index plus a one-hot flag; all sequential logic shall stay in keypad_debounce_encoder.

Verification (bench uses DB_CYCLES=4)
REQ-030 Reset: rst_n=0 with A=10'b1101111111 -> all outputs 0; after rst_n=1 with A held, KEY_VALID pulses once at the edge given by REQ-017 with DIGIT=7.
REQ-031 Clean press: A=10'b1111110111 for 20 cycles, then 10'b1111111111 -> exactly one KEY_VALID pulse with DIGIT=3; KEY_HELD falls 4 cycles after the synchronized release.
REQ-032 Bounce: A alternates 10'b1011111111 and all-ones every 2 cycles for 12 cycles, then holds 10'b1011111111 -> exactly one KEY_VALID pulse with DIGIT=8, no MULTI_ERR.
REQ-033 Two keys: A=10'b1111100111 (keys 3 and 4) stable -> MULTI_ERR pulses once, KEY_VALID stays 0, DIGIT keeps its prior value.
REQ-034 Roll-over: press 8, add 9 while held, release 8, then release all, then press 9 alone -> first KEY_VALID with DIGIT=8, none during the roll-over, second KEY_VALID with DIGIT=9.
REQ-035 Reset mid-debounce: press 2 and assert rst_n=0 after 2 cycles -> no KEY_VALID pulse and DIGIT=0.
